pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequences the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
//  Decides per cycle: enable/flush for every latch, PC source, iREN; detects load-use
//  hazards, redirects on branch/jump resolved in MEM, stalls on data-memory wait, drains on halt.
//  Sits beside the datapath; reads EX/MEM, ID/EX, IF/ID latch outputs; drives their en/flush pins.
// PARAMETERS
//  DRAIN_CYCLES  2   cycles spent draining MEM/WB after halt reaches MEM (>=1)
//  CNT_W         16  width of saturating stall/flush performance counters
// PORTS
//  CLK            in   1      clock, all state on rising edge
//  RST            in   1      synchronous reset, active-high
//  ihit / dhit    in   1/1    instruction / data memory access complete this cycle
//  exmem_dREN/dWEN in  1/1    MEM-stage instr reads / writes data memory
//  exmem_beq/bne  in   1/1    MEM-stage instr is beq / bne
//  exmem_flagZero in   1      ALU zero flag latched in EX/MEM
//  exmem_jump/jr  in   1/1    MEM-stage instr is j/jal / jr
//  exmem_halt     in   1      MEM-stage instr is halt
//  idex_dREN      in   1      EX-stage instr is a load
//  idex_dest_reg  in   5      EX-stage destination register
//  ifid_rs/rt     in   5/5    ID-stage source registers
//  ifid_uses_rt   in   1      ID-stage instr reads rt
//  pc_en          out  1      PC register load enable
//  pc_sel         out  2      0 pc+4, 1 branch_addr, 2 jump target, 3 rdat1 (jr)
//  iREN           out  1      instruction fetch request
//  ifid_en/flush, idex_en/flush, exmem_en/flush, memwb_en/flush  out 1 each: latch load / load-bubble
//  halt           out  1      sticky: processor halted
//  stall_cnt      out  CNT_W  cycles with pc_en=0 in RUN, saturating
//  flush_cnt      out  CNT_W  redirects taken, saturating
// BEHAVIOUR
//  Reset (RST=1 at edge): state=RUN, drain_cnt=0, stall_cnt=flush_cnt=0. While RST high, outputs
//   forced: all *_en=0, all *_flush=1, pc_sel=0, iREN=0, halt=0.
//  FSM: RUN -> DRAIN (halt seen) -> HALTED (drain_cnt==0); HALTED exits only by RST.
//  Outputs combinational from state+inputs; flush has priority over en inside each latch.
//  RUN, priority highest first (exactly one applies per cycle):
//   1 dwait = (exmem_dREN|exmem_dWEN)&~dhit: all *_en=0 except memwb_flush=1; pc_en=0.
//   2 halt = exmem_halt: pc_en=0, ifid/idex/exmem_flush=1, memwb_en=1; next state DRAIN,
//     drain_cnt<=DRAIN_CYCLES-1. halt beats redirect if both flagged.
//   3 redirect = (beq&flagZero)|(bne&~flagZero)|jump|jr: pc_en=1, pc_sel=1/2/3 (jr>jump>branch),
//     ifid/idex/exmem_flush=1, memwb_en=1; flush_cnt++. Ignores ihit.
//   4 loaduse = idex_dREN & idex_dest_reg!=0 & (dest==ifid_rs | (ifid_uses_rt & dest==ifid_rt)):
//     pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1. One bubble per match.
//   5 ~ihit: pc_en=0, ifid_flush=1, idex/exmem/memwb_en=1.
//   6 else: all *_en=1, flushes 0, pc_sel=0.
//   iREN = ~(exmem_dREN|exmem_dWEN) in RUN (data access owns shared memory), 0 otherwise.
//   stall_cnt++ on every RUN cycle with pc_en=0; both counters saturate at all-ones.
//  DRAIN: pc_en=0, iREN=0, ifid/idex/exmem_flush=1, memwb_en=1; drain_cnt-- each cycle;
//   at drain_cnt==0 next=HALTED. Lasts exactly DRAIN_CYCLES cycles. Counters frozen.
//  HALTED: all *_en=0, flushes 0, iREN=0, halt=1. Counters frozen.
//  Reset mid-DRAIN/mid-stall: returns to RUN next cycle, counters cleared, no residual bubble.
//  Register $0 never creates a load-use stall.
// TESTING
//  1 Reset: RST=1 2 cycles -> all en=0, flush=1, halt=0; release -> RUN, ihit=1 -> all en=1, pc_sel=0.
//  2 Load-use: idex_dREN=1,dest=5, ifid_rs=5 -> 1 cycle pc_en=0,ifid_en=0,idex_flush=1; dest=0 -> no stall.
//  3 Branch: exmem_beq=1,flagZero=1 -> pc_sel=1, 3 flushes, flush_cnt 0->1; bne with flagZero=1 -> no redirect.
//  4 Dmem wait: exmem_dREN=1, dhit=0 for 3 cycles + simultaneous load-use -> all en=0,
//    memwb_flush=1, iREN=0, stall_cnt=3; dhit=1 -> load-use/advance resumes.
//  5 Halt: exmem_halt=1 -> DRAIN 2 cycles (memwb_en=1), then halt=1 sticky; RST in DRAIN -> RUN.
//  6 Saturation: CNT_W=4, hold ihit=0 20 cycles -> stall_cnt=15, stays 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and sequencing controller for a 5-stage pipeline. Each cycle it decides
//   the load enable and bubble (flush) for every pipeline latch, where the PC loads
//   from, and whether instruction fetch may use the shared memory port. It also
//   detects load-use hazards, redirects on branch/jump resolved in MEM, stalls on
//   data-memory wait and drains the pipe on halt.
//
//   Handshake: ihit/dhit mark that a memory access completes in the current cycle.
//   A latch loads on a rising edge when its *_en is high; *_flush loads a bubble
//   and takes precedence over *_en.
//
// Ports
//   CLK, RST                     clock, synchronous active-high reset
//   ihit, dhit                   instruction / data memory access complete
//   exmem_*                      MEM-stage instruction attributes
//   idex_dREN, idex_dest_reg     EX-stage load flag and destination register
//   ifid_rs, ifid_rt, ifid_uses_rt  ID-stage source registers
//   pc_en, pc_sel                PC load enable and source (0 pc+4, 1 branch, 2 jump, 3 jr)
//   iREN                         instruction fetch request
//   <latch>_en, <latch>_flush    latch load / bubble controls
//   halt                         processor halted (holds until reset)
//   stall_cnt, flush_cnt         saturating performance counters
//   dbg_state                    current FSM state (0 RUN, 1 DRAIN, 2 HALTED)

module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             exmem_beq,
    input  logic             exmem_bne,
    input  logic             exmem_flagZero,
    input  logic             exmem_jump,
    input  logic             exmem_jr,
    input  logic             exmem_halt,
    input  logic             idex_dREN,
    input  logic [4:0]       idex_dest_reg,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             iREN,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbg_state
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  drain_q, drain_d;
    logic           take_redirect;

    logic dmem_access, dwait, redirect, loaduse;

    assign dmem_access = exmem_dREN | exmem_dWEN;
    assign dwait       = dmem_access & ~dhit;
    assign redirect    = (exmem_beq & exmem_flagZero) | (exmem_bne & ~exmem_flagZero)
                       | exmem_jump | exmem_jr;
    // $0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign loaduse     = idex_dREN & (idex_dest_reg != 5'd0)
                       & ((idex_dest_reg == ifid_rs)
                          | (ifid_uses_rt & (idex_dest_reg == ifid_rt)));

    assign dbg_state = state_q;

    always_comb begin
        pc_en         = 1'b0;
        pc_sel        = 2'd0;
        iREN          = 1'b0;
        ifid_en       = 1'b0;
        ifid_flush    = 1'b0;
        idex_en       = 1'b0;
        idex_flush    = 1'b0;
        exmem_en      = 1'b0;
        exmem_flush   = 1'b0;
        memwb_en      = 1'b0;
        memwb_flush   = 1'b0;
        halt          = 1'b0;
        take_redirect = 1'b0;
        state_d       = state_q;
        drain_d       = drain_q;

        if (RST) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    // The data access owns the shared memory port while it is in MEM.
                    iREN = ~dmem_access;
                    if (dwait) begin
                        // Freeze everything; WB gets a bubble so a write-back is not repeated.
                        memwb_flush = 1'b1;
                    end else if (exmem_halt) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        memwb_en    = 1'b1;
                        state_d     = ST_DRAIN;
                        drain_d     = DW'(DRAIN_CYCLES - 1);
                    end else if (redirect) begin
                        pc_en         = 1'b1;
                        pc_sel        = exmem_jr ? 2'd3 : (exmem_jump ? 2'd2 : 2'd1);
                        ifid_flush    = 1'b1;
                        idex_flush    = 1'b1;
                        exmem_flush   = 1'b1;
                        memwb_en      = 1'b1;
                        take_redirect = 1'b1;
                    end else if (loaduse) begin
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else if (!ihit) begin
                        ifid_flush = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    memwb_en    = 1'b1;
                    if (drain_q == '0) begin
                        state_d = ST_HALTED;
                    end else begin
                        drain_d = drain_q - DW'(1);
                    end
                end
                ST_HALTED: begin
                    halt = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_RUN;
            drain_q   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if ((state_q == ST_RUN) && !pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (take_redirect && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed vectors, expected responses queued per
// cycle and checked by an independent monitor on the falling clock edge. A second
// instance with 4-bit counters shares all inputs to observe counter saturation.

module tb_pipe_hazard_ctrl;

    localparam int W = 55;

    localparam logic [1:0] S_RUN = 2'd0, S_DRAIN = 2'd1, S_HALTED = 2'd2;

    // {pc_en, pc_sel[1:0], iREN, ifid en/fl, idex en/fl, exmem en/fl, memwb en/fl, halt}
    localparam logic [12:0] C_RST       = 13'b0_00_0_01_01_01_01_0;
    localparam logic [12:0] C_NORM      = 13'b1_00_1_10_10_10_10_0;
    localparam logic [12:0] C_LU        = 13'b0_00_1_00_01_10_10_0;
    localparam logic [12:0] C_LU_NOIREN = 13'b0_00_0_00_01_10_10_0;
    localparam logic [12:0] C_IMISS     = 13'b0_00_1_01_10_10_10_0;
    localparam logic [12:0] C_RBR       = 13'b1_01_1_01_01_01_10_0;
    localparam logic [12:0] C_RJ        = 13'b1_10_1_01_01_01_10_0;
    localparam logic [12:0] C_RJR       = 13'b1_11_1_01_01_01_10_0;
    localparam logic [12:0] C_RJ_NOIREN = 13'b1_10_0_01_01_01_10_0;
    localparam logic [12:0] C_DWAIT     = 13'b0_00_0_00_00_00_01_0;
    localparam logic [12:0] C_HALTRUN   = 13'b0_00_1_01_01_01_10_0;
    localparam logic [12:0] C_DRAIN     = 13'b0_00_0_01_01_01_10_0;
    localparam logic [12:0] C_HALTED    = 13'b0_00_0_00_00_00_00_1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic ihit, dhit, dren, dwen, beq, bne, fz, jump, jr, hlt, idex_dren, uses_rt;
    logic [4:0] dest, rs, rt;

    logic pc_en, iren, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl;
    logic memwb_en, memwb_fl, halt_o;
    logic [1:0] pc_sel, dbg_state;
    logic [15:0] stall_cnt, flush_cnt;

    logic s_pc_en, s_iren, s_ifid_en, s_ifid_fl, s_idex_en, s_idex_fl, s_exmem_en, s_exmem_fl;
    logic s_memwb_en, s_memwb_fl, s_halt;
    logic [1:0] s_pc_sel, s_dbg_state;
    logic [3:0] s_stall_cnt, s_flush_cnt;

    pipe_hazard_ctrl dut (
        .CLK(clk), .RST(rst), .ihit(ihit), .dhit(dhit),
        .exmem_dREN(dren), .exmem_dWEN(dwen), .exmem_beq(beq), .exmem_bne(bne),
        .exmem_flagZero(fz), .exmem_jump(jump), .exmem_jr(jr), .exmem_halt(hlt),
        .idex_dREN(idex_dren), .idex_dest_reg(dest), .ifid_rs(rs), .ifid_rt(rt),
        .ifid_uses_rt(uses_rt),
        .pc_en(pc_en), .pc_sel(pc_sel), .iREN(iren),
        .ifid_en(ifid_en), .ifid_flush(ifid_fl), .idex_en(idex_en), .idex_flush(idex_fl),
        .exmem_en(exmem_en), .exmem_flush(exmem_fl), .memwb_en(memwb_en), .memwb_flush(memwb_fl),
        .halt(halt_o), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dbg_state(dbg_state)
    );

    pipe_hazard_ctrl #(.DRAIN_CYCLES(2), .CNT_W(4)) dut_sat (
        .CLK(clk), .RST(rst), .ihit(ihit), .dhit(dhit),
        .exmem_dREN(dren), .exmem_dWEN(dwen), .exmem_beq(beq), .exmem_bne(bne),
        .exmem_flagZero(fz), .exmem_jump(jump), .exmem_jr(jr), .exmem_halt(hlt),
        .idex_dREN(idex_dren), .idex_dest_reg(dest), .ifid_rs(rs), .ifid_rt(rt),
        .ifid_uses_rt(uses_rt),
        .pc_en(s_pc_en), .pc_sel(s_pc_sel), .iREN(s_iren),
        .ifid_en(s_ifid_en), .ifid_flush(s_ifid_fl), .idex_en(s_idex_en), .idex_flush(s_idex_fl),
        .exmem_en(s_exmem_en), .exmem_flush(s_exmem_fl), .memwb_en(s_memwb_en),
        .memwb_flush(s_memwb_fl), .halt(s_halt), .stall_cnt(s_stall_cnt),
        .flush_cnt(s_flush_cnt), .dbg_state(s_dbg_state)
    );

    logic [12:0] act_ctl, act_sat_ctl;
    assign act_ctl = {pc_en, pc_sel, iren, ifid_en, ifid_fl, idex_en, idex_fl,
                      exmem_en, exmem_fl, memwb_en, memwb_fl, halt_o};
    assign act_sat_ctl = {s_pc_en, s_pc_sel, s_iren, s_ifid_en, s_ifid_fl, s_idex_en, s_idex_fl,
                          s_exmem_en, s_exmem_fl, s_memwb_en, s_memwb_fl, s_halt};

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input string fld, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear();
        ihit = 1'b1; dhit = 1'b1; dren = 1'b0; dwen = 1'b0; beq = 1'b0; bne = 1'b0;
        fz = 1'b0; jump = 1'b0; jr = 1'b0; hlt = 1'b0; idex_dren = 1'b0; uses_rt = 1'b0;
        dest = 5'd0; rs = 5'd0; rt = 5'd0;
    endtask

    // Inputs for the current cycle are already applied; queue what the outputs must
    // be this cycle, then advance to just past the next rising edge.
    task automatic cyc(input string nm, input logic [12:0] ctl, input logic [1:0] st,
                       input int s, input int f);
        logic [3:0] ss, sf;
        ss = (s > 15) ? 4'd15 : 4'(s);
        sf = (f > 15) ? 4'd15 : 4'(f);
        exp_q.push_back({ctl, st, 16'(s), 16'(f), ss, sf});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, "ctl",       16'(act_ctl),     16'(e[54:42]));
                chk(nm, "state",     16'(dbg_state),   16'(e[41:40]));
                chk(nm, "stall_cnt", stall_cnt,        e[39:24]);
                chk(nm, "flush_cnt", flush_cnt,        e[23:8]);
                chk(nm, "sat_ctl",   16'(act_sat_ctl), 16'(e[54:42]));
                chk(nm, "sat_stall", 16'(s_stall_cnt), 16'(e[7:4]));
                chk(nm, "sat_flush", 16'(s_flush_cnt), 16'(e[3:0]));
                if (s_dbg_state !== dbg_state) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL %s.sat_state: got %0d expected %0d", nm, s_dbg_state, dbg_state);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d entries pending", exp_q.size());
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        clear();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // reset and release
        cyc("rst0", C_RST, S_RUN, 0, 0);
        cyc("rst1", C_RST, S_RUN, 0, 0);
        rst = 1'b0;
        cyc("run0", C_NORM, S_RUN, 0, 0);
        cyc("run1", C_NORM, S_RUN, 0, 0);

        // load-use
        idex_dren = 1'b1; dest = 5'd5; rs = 5'd5;
        cyc("lu_rs", C_LU, S_RUN, 0, 0);
        clear();
        cyc("lu_after", C_NORM, S_RUN, 1, 0);
        idex_dren = 1'b1; dest = 5'd0; rs = 5'd0;
        cyc("lu_r0", C_NORM, S_RUN, 1, 0);
        clear(); idex_dren = 1'b1; dest = 5'd7; rs = 5'd3; rt = 5'd7; uses_rt = 1'b1;
        cyc("lu_rt", C_LU, S_RUN, 1, 0);
        uses_rt = 1'b0;
        cyc("lu_rt_unused", C_NORM, S_RUN, 2, 0);

        // branches and jumps
        clear(); beq = 1'b1; fz = 1'b1;
        cyc("beq_taken", C_RBR, S_RUN, 2, 0);
        clear();
        cyc("after_beq", C_NORM, S_RUN, 2, 1);
        bne = 1'b1; fz = 1'b1;
        cyc("bne_not_taken", C_NORM, S_RUN, 2, 1);
        fz = 1'b0;
        cyc("bne_taken", C_RBR, S_RUN, 2, 1);
        clear(); jump = 1'b1; beq = 1'b1; fz = 1'b1;
        cyc("jump_over_br", C_RJ, S_RUN, 2, 2);
        clear(); jr = 1'b1; jump = 1'b1; ihit = 1'b0;
        cyc("jr_over_j_imiss", C_RJR, S_RUN, 2, 3);
        clear();
        cyc("after_jr", C_NORM, S_RUN, 2, 4);
        ihit = 1'b0;
        cyc("imiss", C_IMISS, S_RUN, 2, 4);
        clear();
        cyc("after_imiss", C_NORM, S_RUN, 3, 4);

        // data-memory wait with a pending load-use
        dren = 1'b1; dhit = 1'b0; idex_dren = 1'b1; dest = 5'd5; rs = 5'd5;
        cyc("dwait0", C_DWAIT, S_RUN, 3, 4);
        cyc("dwait1", C_DWAIT, S_RUN, 4, 4);
        cyc("dwait2", C_DWAIT, S_RUN, 5, 4);
        dhit = 1'b1;
        cyc("lu_resume", C_LU_NOIREN, S_RUN, 6, 4);
        clear();
        cyc("after_dwait", C_NORM, S_RUN, 7, 4);
        dwen = 1'b1; dhit = 1'b0; jump = 1'b1;
        cyc("dwait_over_jump", C_DWAIT, S_RUN, 7, 4);
        dhit = 1'b1;
        cyc("jump_after_dwait", C_RJ_NOIREN, S_RUN, 8, 4);
        clear();
        cyc("after_jump", C_NORM, S_RUN, 8, 5);

        // halt, drain, halted
        hlt = 1'b1; beq = 1'b1; fz = 1'b1;
        cyc("halt_over_br", C_HALTRUN, S_RUN, 8, 5);
        clear();
        cyc("drain0", C_DRAIN, S_DRAIN, 9, 5);
        cyc("drain1", C_DRAIN, S_DRAIN, 9, 5);
        ihit = 1'b0; jump = 1'b1;
        cyc("halted0", C_HALTED, S_HALTED, 9, 5);
        cyc("halted1", C_HALTED, S_HALTED, 9, 5);
        clear(); rst = 1'b1;
        cyc("rst_halted", C_RST, S_HALTED, 9, 5);
        rst = 1'b0;
        cyc("run_after_rst", C_NORM, S_RUN, 0, 0);

        // reset in the middle of a drain
        hlt = 1'b1;
        cyc("halt2", C_HALTRUN, S_RUN, 0, 0);
        clear();
        cyc("drain2", C_DRAIN, S_DRAIN, 1, 0);
        rst = 1'b1;
        cyc("rst_in_drain", C_RST, S_DRAIN, 1, 0);
        rst = 1'b0;
        cyc("run_after_drain_rst", C_NORM, S_RUN, 0, 0);

        // reset in the middle of a stall
        dren = 1'b1; dhit = 1'b0;
        cyc("dwait_pre_rst", C_DWAIT, S_RUN, 0, 0);
        rst = 1'b1;
        cyc("rst_in_stall", C_RST, S_RUN, 1, 0);
        rst = 1'b0; clear();
        cyc("no_residual", C_NORM, S_RUN, 0, 0);

        // stall counter saturation (4-bit instance)
        for (int i = 0; i < 20; i++) begin
            ihit = 1'b0;
            cyc($sformatf("sat_miss%0d", i), C_IMISS, S_RUN, i, 0);
        end
        clear();
        cyc("sat_after", C_NORM, S_RUN, 20, 0);
        ihit = 1'b0;
        cyc("sat_hold", C_IMISS, S_RUN, 20, 0);
        clear();
        cyc("sat_final", C_NORM, S_RUN, 21, 0);

        // let the monitor drain the queue
        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
